// File: rtl/regfile_dump_if.sv
// Bus bundle for regfile_dump: read/write strobes plus the handshaked dump stream.
// master = control/sink side, slave = register file side.
interface regfile_dump_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rsv;
  logic [DATA_W-1:0] rtv;
  logic              wr_en;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] wdata;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              busy;
  logic              done;

  modport master (
    output rd_en, rs, rt, wr_en, rd, wdata, dump_start, dump_ready,
    input  rsv, rtv, dump_valid, dump_addr, dump_data, dump_last, busy, done
  );

  modport slave (
    input  rd_en, rs, rt, wr_en, rd, wdata, dump_start, dump_ready,
    output rsv, rtv, dump_valid, dump_addr, dump_data, dump_last, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// 2**ADDR_W x DATA_W register file, two registered read ports, one write port, reg 0 = 0,
// and a handshaked engine streaming every register in address order. Macro REGFILE_BYPASS_EN enables write forwarding.
module regfile_dump #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_dump_if.slave  bus
);
  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_FIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rsv;
  logic [DATA_W-1:0] r_rtv;
  logic              r_dump_valid;
  logic [ADDR_W-1:0] r_dump_addr;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_dump_last;
  logic              r_busy;
  logic              r_done;

  logic              w_wr_act;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [ADDR_W-1:0] w_dump_inc;
  logic [DATA_W-1:0] w_dump_inc_val;
  logic              w_valid_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_last_nxt;

  assign w_wr_act   = bus.wr_en && (bus.rd != '0);
  assign w_dump_inc = r_dump_addr + ADDR_W'(1);

  // Array lookups; address 0 is never forwarded and always reads 0
  always_comb begin
    w_rs_val       = (bus.rs == '0) ? '0 : r_mem[bus.rs];
    w_rt_val       = (bus.rt == '0) ? '0 : r_mem[bus.rt];
    w_dump_inc_val = (w_dump_inc == '0) ? '0 : r_mem[w_dump_inc];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_act && (bus.rd == bus.rs))     w_rs_val       = bus.wdata;
    if (w_wr_act && (bus.rd == bus.rt))     w_rt_val       = bus.wdata;
    if (w_wr_act && (bus.rd == w_dump_inc)) w_dump_inc_val = bus.wdata;
`endif
  end

  // Dump FSM next state and next stream registers
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_dump_valid;
    w_addr_nxt  = r_dump_addr;
    w_data_nxt  = r_dump_data;
    w_last_nxt  = r_dump_last;
    case (r_state)
      ST_IDLE: begin
        if (bus.dump_start) begin
          w_state_nxt = ST_DUMP;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = '0;
          w_data_nxt  = '0;
          w_last_nxt  = 1'b0;
        end
      end
      ST_DUMP: begin
        if (r_dump_valid && bus.dump_ready) begin
          if (r_dump_last) begin
            w_state_nxt = ST_FIN;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_addr_nxt = w_dump_inc;
            w_data_nxt = w_dump_inc_val;
            w_last_nxt = (w_dump_inc == LAST_ADDR);
          end
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rsv        <= '0;
      r_rtv        <= '0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_dump_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_dump_valid <= w_valid_nxt;
      r_dump_addr  <= w_addr_nxt;
      r_dump_data  <= w_data_nxt;
      r_dump_last  <= w_last_nxt;
      r_busy       <= (w_state_nxt == ST_DUMP);
      r_done       <= (w_state_nxt == ST_FIN);
      if (bus.rd_en) begin
        r_rsv <= w_rs_val;
        r_rtv <= w_rt_val;
      end
      if (w_wr_act) r_mem[bus.rd] <= bus.wdata;
    end
  end

  assign bus.rsv        = r_rsv;
  assign bus.rtv        = r_rtv;
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_last  = r_dump_last;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: constant vector table, directed dump sequences,
// and random traffic compared every cycle against a behavioural array/stream model.
module tb_regfile_dump;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_dump_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain array plus stream position
  logic [7:0] m_mem [DEPTH];
  logic [7:0] e_rsv, e_rtv, e_data;
  logic [4:0] e_addr;
  bit         e_valid, e_busy, e_done;

  typedef struct {
    logic       rd_en;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       wr_en;
    logic [4:0] rd;
    logic [7:0] wdata;
    logic [7:0] exp_rsv;
    logic [7:0] exp_rtv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 8'h00;
    if (BYP && bus.wr_en && (bus.rd == a)) return bus.wdata;
    return m_mem[a];
  endfunction

  task automatic set_idle();
    rst_n          = 1'b1;
    bus.rd_en      = 1'b0;
    bus.rs         = '0;
    bus.rt         = '0;
    bus.wr_en      = 1'b0;
    bus.rd         = '0;
    bus.wdata      = '0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b1;
  endtask

  // Advance the model by one clock with the currently driven inputs, then compare all outputs
  task automatic step();
    bit done_n;
    done_n = 1'b0;
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      e_rsv = 0; e_rtv = 0; e_data = 0; e_addr = 0;
      e_valid = 0; e_busy = 0; e_done = 0;
    end else begin
      if (bus.rd_en) begin
        e_rsv = mread(bus.rs);
        e_rtv = mread(bus.rt);
      end
      if (e_busy) begin
        if (bus.dump_ready) begin
          if (e_addr == 5'd31) begin
            e_busy = 0; e_valid = 0; done_n = 1'b1;
          end else begin
            e_addr = e_addr + 5'd1;
            e_data = mread(e_addr);
          end
        end
      end else if (!e_done && bus.dump_start) begin
        e_busy = 1; e_valid = 1; e_addr = 0; e_data = 0;
      end
      e_done = done_n;
      if (bus.wr_en && bus.rd != 5'd0) m_mem[bus.rd] = bus.wdata;
    end
    @(posedge clk);
    #1;
    chk("rsv", 32'(bus.rsv), 32'(e_rsv));
    chk("rtv", 32'(bus.rtv), 32'(e_rtv));
    chk("dump_valid", 32'(bus.dump_valid), 32'(e_valid));
    chk("dump_addr", 32'(bus.dump_addr), 32'(e_addr));
    chk("dump_data", 32'(bus.dump_data), 32'(e_data));
    chk("dump_last", 32'(bus.dump_last), 32'(e_valid && e_addr == 5'd31));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("done", 32'(bus.done), 32'(e_done));
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.rd = a; bus.wdata = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    vec_t vt [9];
    int   b_addr [$];
    int   b_data [$];
    int   b_last [$];
    int   n_done;
    bit   wrote;
    bit   prev_stall;
    logic [4:0] prev_addr;
    logic [7:0] prev_data;

    foreach (m_mem[i]) m_mem[i] = 8'h00;
    e_rsv = 0; e_rtv = 0; e_data = 0; e_addr = 0;
    e_valid = 0; e_busy = 0; e_done = 0;

    // Reset and reset-clear sequence
    set_idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wr(5'd7, 8'h5A);
    rst_n = 1'b0;
    step();
    chk("rst_rsv", 32'(bus.rsv), 32'h0);
    chk("rst_valid", 32'(bus.dump_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    bus.rd_en = 1'b1; bus.rs = 5'd7; bus.rt = 5'd7;
    step();
    chk("rst_clear_r7", 32'(bus.rsv), 32'h0);
    set_idle();

    // Write/read table with constant expectations
    vt[0] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 8'h3C, 8'h00, 8'h00};
    vt[1] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 8'hFF, 8'h00, 8'h00};
    vt[2] = '{1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 8'h00, 8'h3C, 8'h00};
    vt[3] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 8'h11, 8'h3C, 8'h00};
    vt[4] = '{1'b1, 5'd9, 5'd4, 1'b1, 5'd9, 8'h22, BYP ? 8'h22 : 8'h11, 8'h3C};
    vt[5] = '{1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 8'h00, 8'h22, 8'h22};
    vt[6] = '{1'b0, 5'd4, 5'd4, 1'b1, 5'd4, 8'h77, 8'h22, 8'h22};
    vt[7] = '{1'b1, 5'd4, 5'd31, 1'b0, 5'd0, 8'h00, 8'h77, 8'h00};
    vt[8] = '{1'b1, 5'd0, 5'd4, 1'b1, 5'd0, 8'hAA, 8'h00, 8'h77};
    for (int i = 0; i < 9; i++) begin
      bus.rd_en = vt[i].rd_en; bus.rs = vt[i].rs; bus.rt = vt[i].rt;
      bus.wr_en = vt[i].wr_en; bus.rd = vt[i].rd; bus.wdata = vt[i].wdata;
      step();
      chk($sformatf("vec%0d_rsv", i), 32'(bus.rsv), 32'(vt[i].exp_rsv));
      chk($sformatf("vec%0d_rtv", i), 32'(bus.rtv), 32'(vt[i].exp_rtv));
    end
    set_idle();

    // Full dump with ready held high
    for (int k = 1; k < 32; k++) wr(5'(k), 8'(k + 1));
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      bit acc_last;
      acc_last = 1'b0;
      if (bus.dump_valid) begin
        b_addr.push_back(int'(bus.dump_addr));
        b_data.push_back(int'(bus.dump_data));
        b_last.push_back(int'(bus.dump_last));
        acc_last = bus.dump_last;
      end
      step();
      if (bus.done) n_done++;
      if (acc_last) chk("done_after_last", 32'(bus.done), 32'h1);
    end
    chk("full_beats", 32'(b_addr.size()), 32'd32);
    chk("full_done_count", 32'(n_done), 32'd1);
    foreach (b_addr[i]) begin
      chk($sformatf("full_addr%0d", i), 32'(b_addr[i]), 32'(i));
      chk($sformatf("full_data%0d", i), 32'(b_data[i]), (i == 0) ? 32'h0 : 32'(i + 1));
      chk($sformatf("full_last%0d", i), 32'(b_last[i]), 32'(i == 31));
    end

    // Backpressure with a stalled-beat write and an ignored mid-dump start
    b_addr.delete(); b_data.delete(); b_last.delete();
    wrote = 1'b0;
    prev_stall = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    for (int c = 0; c < 140; c++) begin
      bus.dump_ready = (c % 4 == 0) || (c % 4 == 3);
      bus.dump_start = (c == 30);
      if (prev_stall) begin
        chk("stall_addr", 32'(bus.dump_addr), 32'(prev_addr));
        chk("stall_data", 32'(bus.dump_data), 32'(prev_data));
      end
      if (bus.dump_valid && bus.dump_addr == 5'd5 && !bus.dump_ready && !wrote) begin
        bus.wr_en = 1'b1; bus.rd = 5'd5; bus.wdata = 8'hE5;
        wrote = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
      end
      if (bus.dump_valid && bus.dump_ready) begin
        b_addr.push_back(int'(bus.dump_addr));
        b_data.push_back(int'(bus.dump_data));
      end
      prev_stall = bus.dump_valid && !bus.dump_ready;
      prev_addr  = bus.dump_addr;
      prev_data  = bus.dump_data;
      step();
    end
    set_idle();
    chk("bp_wrote", 32'(wrote), 32'h1);
    chk("bp_beats", 32'(b_addr.size()), 32'd32);
    chk("bp_idle_after", 32'(bus.busy), 32'h0);
    foreach (b_addr[i]) begin
      chk($sformatf("bp_addr%0d", i), 32'(b_addr[i]), 32'(i));
      chk($sformatf("bp_data%0d", i), 32'(b_data[i]), (i == 0) ? 32'h0 : 32'(i + 1));
    end
    bus.rd_en = 1'b1; bus.rs = 5'd5; bus.rt = 5'd6;
    step();
    chk("bp_r5_written", 32'(bus.rsv), 32'hE5);
    set_idle();

    // Reset in the middle of a dump
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    for (int c = 0; c < 50 && !(bus.dump_valid && bus.dump_addr == 5'd10); c++) step();
    chk("mid_at_beat10", 32'(bus.dump_addr), 32'd10);
    rst_n = 1'b0;
    step();
    chk("mid_valid", 32'(bus.dump_valid), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.done) n_done++;
    end
    chk("mid_no_done", 32'(n_done), 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      bus.rd_en      = 1'($urandom_range(0, 1));
      bus.wr_en      = 1'($urandom_range(0, 1));
      bus.rs         = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.rt         = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.rd         = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      bus.wdata      = 8'($urandom_range(0, 255));
      bus.dump_start = ($urandom_range(0, 15) == 0);
      bus.dump_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    set_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Parametrised successor to the multi-cycle CPU register file. It is a `2**ADDR_W` x `DATA_W` array with:
- two registered read ports and one write port;
- register 0 hardwired to zero;
- synchronous clear on reset;
- a handshaked dump engine that streams every register out in address order, replacing the old single-register output state.

It sits between the control FSM (read/write strobes) and the testbench/debug sink (dump stream).

## Interface
Parameters:
- `DATA_W`, 8, register width in bits
- `ADDR_W`, 5, address width; depth = `2**ADDR_W`

Ports:
- `clk`  in  1  clock, all activity on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `rd_en`  in  1  read strobe for `rs`/`rt`
- `rs`  in  `ADDR_W`  read address A
- `rt`  in  `ADDR_W`  read address B
- `rsv`  out  `DATA_W`  read data A, registered
- `rtv`  out  `DATA_W`  read data B, registered
- `wr_en`  in  1  write strobe
- `rd`  in  `ADDR_W`  write address
- `wdata`  in  `DATA_W`  write data
- `dump_start`  in  1  request full-array dump
- `dump_valid`  out  1  dump beat valid
- `dump_ready`  in  1  sink accepts beat
- `dump_addr`  out  `ADDR_W`  address of current beat
- `dump_data`  out  `DATA_W`  contents of `dump_addr`
- `dump_last`  out  1  current beat is address `2**ADDR_W-1`
- `busy`  out  1  dump in progress (state DUMP)
- `done`  out  1  one-cycle pulse after last beat accepted

## Operation
- **Reset:** `rst_n`=0 at a rising edge forces the following:
  - all array entries become 0;
  - `rsv`, `rtv`, `dump_addr` and `dump_data` become 0;
  - `dump_valid`, `dump_last`, `busy` and `done` become 0;
  - state becomes IDLE.

  This applies mid-dump too: the stream is abandoned and no `done` pulse is issued.
- **Read:** with `rd_en`=1, `rsv`<=`regfile[rs]` and `rtv`<=`regfile[rt]`. With `rd_en`=0, `rsv`/`rtv` hold.
- **Address 0:** always reads 0.
- **Write:** with `wr_en`=1 and `rd`!=0, `regfile[rd]`<=`wdata`. Writes to 0 are discarded. Writes are accepted in every state, including DUMP.
- **Read and write to the same address in the same cycle:** the read returns the old value (see Configuration for the bypass option).
- **Dump FSM states:** IDLE, DUMP, FIN.
  - **IDLE:**
    - `dump_start`=1 -> DUMP.
    - Entering DUMP loads `dump_addr`=0, `dump_data`=0, `dump_valid`=1, `dump_last`=0.
  - **DUMP:**
    - On `dump_valid`&&`dump_ready` with `dump_last`=0: `dump_addr`++ and `dump_data`<=`regfile[dump_addr+1]` as the array held before that edge.
    - `dump_last` is set when the new address is `2**ADDR_W-1`.
    - On an accepted beat with `dump_last`=1 -> FIN, with `dump_valid`=0.
    - While `dump_ready`=0, `dump_addr`, `dump_data` and `dump_last` hold stable, even if that address is written meanwhile.
  - **FIN:** `done`=1 for exactly this cycle, then IDLE.
- `dump_start` while in DUMP or FIN is ignored; it is not queued.
- `busy`=1 exactly while the state is DUMP.
- No arithmetic beyond the address increment. `dump_addr` never wraps, because the FSM leaves DUMP at the top address.

## Timing
- Read latency is 1 cycle: data is visible after the edge that samples `rd_en`.
- Write latency is 1 cycle: a read strobed on the edge after a write sees the new value.
- Dump start: `dump_valid` rises 1 cycle after `dump_start` is sampled.
- With `dump_ready` held at 1, a dump takes `2**ADDR_W` beats on consecutive cycles (32 for the defaults).
- After the last accepted beat: `done` pulses on the next cycle, and `busy` drops on that same edge.
- Minimum time from one `dump_start` to the next accepted `dump_start`: `2**ADDR_W`+2 cycles.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** a read in the same cycle as a write with `rs` or `rt` equal to a nonzero `rd` returns `wdata` on that port.
  - The dump data load also forwards a same-cycle write to the address being loaded.
- **Undefined:** no forwarding; the pre-write array contents are returned.
- Address 0 is never forwarded in either mode.

## Test plan
- **Reset clear:** write 0x5A to reg 7, then assert `rst_n`=0 for 1 cycle, then read `rs`=7 -> `rsv`=0x00, all outputs 0.
- **Write/read and zero register:** write 0x3C to reg 4 and 0xFF to reg 0, then read `rs`=4, `rt`=0 -> `rsv`=0x3C, `rtv`=0x00 one cycle after `rd_en`.
- **Same-cycle hazard:** reg 9 = 0x11. Write 0x22 to reg 9 while `rd_en` with `rs`=9.
  - Without macro -> `rsv`=0x11.
  - With `REGFILE_BYPASS_EN` -> `rsv`=0x22.
- **Full dump, `dump_ready`=1:** preload reg k = k+1 for k=1..31, pulse `dump_start` -> 32 consecutive beats.
  - Beat 0 carries 0x00; beat k carries k+1.
  - `dump_last` is set only on addr 31.
  - `done` pulses 1 cycle after beat 31.
- **Backpressure:** toggle `dump_ready` 1-0-0-1 repeatedly, and write reg 5 while beat 5 is stalled.
  - Addr/data stay stable while stalled, and beat 5 shows the pre-stall value.
  - No beat is skipped or duplicated.
  - A `dump_start` pulse during the dump is ignored.
- **Reset mid-dump:** assert `rst_n`=0 at beat 10 -> `dump_valid`, `busy` and `done` are 0 next cycle, and no `done` pulse follows.
